// File: rtl/ramworks_cmd_ctrl.sv
// RAMWorks bank register, capacity mask and key-sequence command decoder.
// The sequence FF 00 55 AA C1 AD <cmd> <arg> drives UFM/config actions.
module ramworks_cmd_ctrl #(
    parameter int TO_BITS = 3
) (
    input  logic       C14M,
    input  logic       Reset,
    input  logic       WrStb,
    input  logic [7:0] WrData,
    input  logic       CycStb,
    input  logic       InitMaskVld,
    input  logic [7:0] InitMask,
    output logic [7:0] RWBank,
    output logic [7:0] RWMask,
    output logic       CmdPrgm,
    output logic       CmdErase,
    output logic       BbDRDIn,
    output logic       BbDRCLK,
    output logic [2:0] CmdState
);

    typedef enum logic [2:0] {
        CS0 = 3'd0,
        CS1 = 3'd1,
        CS2 = 3'd2,
        CS3 = 3'd3,
        CS4 = 3'd4,
        CS5 = 3'd5,
        CS6 = 3'd6,
        CS7 = 3'd7
    } cs_t;

    cs_t                r_cs;
    logic [TO_BITS-1:0] r_to;
    logic [7:0]         r_rwbank;
    logic [7:0]         r_rwmask;
    logic               r_rstnext;
    logic               r_bbarm;
    logic               r_maskarm;
    logic               r_prgm;
    logic               r_erase;
    logic               r_bbdrdin;
    logic               r_bbdrclk;

    logic [7:0] w_key;
    cs_t        w_cs_nxt;
    logic       w_key_hit;
    logic       w_to_full;
    logic [7:0] w_init_mask;

    // Expected key byte and successor for the key-matching states
    always_comb begin
        w_key    = 8'h00;
        w_cs_nxt = CS0;
        case (r_cs)
            CS0: begin
                w_key    = 8'hFF;
                w_cs_nxt = CS1;
            end
            CS1: begin
                w_key    = 8'h00;
                w_cs_nxt = CS2;
            end
            CS2: begin
                w_key    = 8'h55;
                w_cs_nxt = CS3;
            end
            CS3: begin
                w_key    = 8'hAA;
                w_cs_nxt = CS4;
            end
            CS4: begin
                w_key    = 8'hC1;
                w_cs_nxt = CS5;
            end
            CS5: begin
                w_key    = 8'hAD;
                w_cs_nxt = CS6;
            end
            default: begin
                w_key    = 8'h00;
                w_cs_nxt = CS0;
            end
        endcase
    end

    assign w_key_hit   = (WrData == w_key);
    assign w_to_full   = &r_to;
    assign w_init_mask = (InitMask == 8'h80) ? 8'h00 : ~InitMask;

    always_ff @(posedge C14M) begin
        if (Reset) begin
            r_cs      <= CS0;
            r_to      <= '0;
            r_rwbank  <= 8'h00;
            r_rwmask  <= 8'h00;
            r_rstnext <= 1'b0;
            r_bbarm   <= 1'b0;
            r_maskarm <= 1'b0;
            r_prgm    <= 1'b0;
            r_erase   <= 1'b0;
            r_bbdrdin <= 1'b0;
            r_bbdrclk <= 1'b0;
        end else begin
            r_prgm    <= 1'b0;
            r_erase   <= 1'b0;
            r_bbdrclk <= 1'b0;
            if (WrStb) begin
                r_to      <= '0;
                r_bbarm   <= 1'b0;
                r_maskarm <= 1'b0;
                if (r_rstnext) begin
                    r_rwbank  <= 8'h00;
                    r_rstnext <= 1'b0;
                end else begin
                    r_rwbank <= WrData & ~r_rwmask;
                end
                case (r_cs)
                    CS6: begin
                        r_cs <= CS7;
                        case (WrData)
                            8'hEF:   r_prgm    <= 1'b1;
                            8'hEE:   r_erase   <= 1'b1;
                            8'hFF:   r_rstnext <= 1'b1;
                            8'hEA:   r_bbarm   <= 1'b1;
                            8'hE0:   r_maskarm <= 1'b1;
                            default: ;
                        endcase
                    end
                    CS7: begin
                        r_cs <= CS0;
                        if (r_bbarm) begin
                            r_bbdrdin <= WrData[6];
                            r_bbdrclk <= WrData[7];
                        end
                        if (r_maskarm) begin
                            r_rwmask <= ~WrData;
                        end
                    end
                    default: begin
                        r_cs <= w_key_hit ? w_cs_nxt : CS0;
                    end
                endcase
            end else if (CycStb) begin
                if (w_to_full) begin
                    r_cs      <= CS0;
                    r_bbarm   <= 1'b0;
                    r_maskarm <= 1'b0;
                    r_to      <= '0;
                end else begin
                    r_to <= r_to + {{(TO_BITS-1){1'b0}}, 1'b1};
                end
            end
            // Loader value overrides a simultaneous mask-set argument
            if (InitMaskVld) begin
                r_rwmask <= w_init_mask;
            end
        end
    end

    assign RWBank   = r_rwbank;
    assign RWMask   = r_rwmask;
    assign CmdPrgm  = r_prgm;
    assign CmdErase = r_erase;
    assign BbDRDIn  = r_bbdrdin;
    assign BbDRCLK  = r_bbdrclk;
    assign CmdState = r_cs;

endmodule

// File: tb/tb_ramworks_cmd_ctrl.sv
// Bench for ramworks_cmd_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the key/command rules.
module tb_ramworks_cmd_ctrl;

    localparam int TO_BITS = 3;
    localparam int TO_MAX  = (1 << TO_BITS) - 1;

    logic       C14M = 1'b0;
    logic       Reset = 1'b1;
    logic       WrStb = 1'b0;
    logic [7:0] WrData = 8'h00;
    logic       CycStb = 1'b0;
    logic       InitMaskVld = 1'b0;
    logic [7:0] InitMask = 8'h00;
    logic [7:0] RWBank;
    logic [7:0] RWMask;
    logic       CmdPrgm;
    logic       CmdErase;
    logic       BbDRDIn;
    logic       BbDRCLK;
    logic [2:0] CmdState;

    int checks = 0;
    int errors = 0;

    logic [7:0] KEY [0:5] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD};
    logic [7:0] CMDS [0:5] = '{8'hEF, 8'hEE, 8'hFF, 8'hEA, 8'hE0, 8'h37};

    int         m_cs;
    int         m_to;
    bit         m_rst;
    bit         m_bb;
    bit         m_mk;
    logic [7:0] e_bank;
    logic [7:0] e_mask;
    bit         e_prgm;
    bit         e_erase;
    bit         e_din;
    bit         e_clk;

    ramworks_cmd_ctrl #(.TO_BITS(TO_BITS)) dut (
        .C14M       (C14M),
        .Reset      (Reset),
        .WrStb      (WrStb),
        .WrData     (WrData),
        .CycStb     (CycStb),
        .InitMaskVld(InitMaskVld),
        .InitMask   (InitMask),
        .RWBank     (RWBank),
        .RWMask     (RWMask),
        .CmdPrgm    (CmdPrgm),
        .CmdErase   (CmdErase),
        .BbDRDIn    (BbDRDIn),
        .BbDRCLK    (BbDRCLK),
        .CmdState   (CmdState)
    );

    always #35 C14M = ~C14M;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cs = 0; m_to = 0; m_rst = 0; m_bb = 0; m_mk = 0;
        e_bank = 8'h00; e_mask = 8'h00;
        e_prgm = 0; e_erase = 0; e_din = 0; e_clk = 0;
    endtask

    task automatic model(input bit rst, input bit wr, input logic [7:0] d,
                         input bit cyc, input bit iv, input logic [7:0] im);
        bit arm_bb;
        bit arm_mk;
        if (rst) begin
            model_reset();
            return;
        end
        e_prgm = 0; e_erase = 0; e_clk = 0;
        if (wr) begin
            m_to = 0;
            arm_bb = m_bb;
            arm_mk = m_mk;
            m_bb = 0;
            m_mk = 0;
            if (m_rst) begin
                e_bank = 8'h00;
                m_rst = 0;
            end else begin
                e_bank = d & ~e_mask;
            end
            if (m_cs < 6) begin
                m_cs = (d == KEY[m_cs]) ? m_cs + 1 : 0;
            end else if (m_cs == 6) begin
                m_cs = 7;
                if (d == 8'hEF) e_prgm = 1;
                if (d == 8'hEE) e_erase = 1;
                if (d == 8'hFF) m_rst = 1;
                if (d == 8'hEA) m_bb = 1;
                if (d == 8'hE0) m_mk = 1;
            end else begin
                m_cs = 0;
                if (arm_bb) begin
                    e_din = d[6];
                    e_clk = d[7];
                end
                if (arm_mk) e_mask = ~d;
            end
        end else if (cyc) begin
            if (m_to == TO_MAX) begin
                m_cs = 0; m_bb = 0; m_mk = 0; m_to = 0;
            end else begin
                m_to++;
            end
        end
        if (iv) e_mask = (im == 8'h80) ? 8'h00 : ~im;
    endtask

    task automatic check_all();
        chk("bank", RWBank, e_bank);
        chk("mask", RWMask, e_mask);
        chk("cs", {5'b0, CmdState}, 8'(m_cs));
        chk("prgm", {7'b0, CmdPrgm}, {7'b0, e_prgm});
        chk("erase", {7'b0, CmdErase}, {7'b0, e_erase});
        chk("drdin", {7'b0, BbDRDIn}, {7'b0, e_din});
        chk("drclk", {7'b0, BbDRCLK}, {7'b0, e_clk});
    endtask

    task automatic step(input bit rst, input bit wr, input logic [7:0] d,
                        input bit cyc, input bit iv, input logic [7:0] im);
        Reset = rst; WrStb = wr; WrData = d;
        CycStb = cyc; InitMaskVld = iv; InitMask = im;
        @(posedge C14M);
        model(rst, wr, d, cyc, iv, im);
        #1;
        check_all();
        Reset = 0; WrStb = 0; CycStb = 0; InitMaskVld = 0;
    endtask

    task automatic wr(input logic [7:0] d);
        step(0, 1, d, 0, 0, 8'h00);
    endtask

    task automatic cyc();
        step(0, 0, 8'h00, 1, 0, 8'h00);
    endtask

    task automatic idle();
        step(0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic rst();
        step(1, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic key(input int n);
        for (int k = 0; k < n; k++) wr(KEY[k]);
    endtask

    initial begin
        model_reset();
        rst();
        chk("t1_rst_bank", RWBank, 8'h00);
        chk("t1_rst_cs", {5'b0, CmdState}, 8'h00);
        wr(8'h3C);
        chk("t1_bank", RWBank, 8'h3C);
        chk("t1_cs", {5'b0, CmdState}, 8'h00);

        rst();
        key(6);
        chk("t2_cs6", {5'b0, CmdState}, 8'h06);
        wr(8'hEF);
        chk("t2_prgm", {7'b0, CmdPrgm}, 8'h01);
        chk("t2_cs7", {5'b0, CmdState}, 8'h07);
        idle();
        chk("t2_prgm_off", {7'b0, CmdPrgm}, 8'h00);
        chk("t2_erase", {7'b0, CmdErase}, 8'h00);

        rst();
        key(6); wr(8'hE0); wr(8'hF0);
        chk("t3_mask", RWMask, 8'h0F);
        chk("t3_cs", {5'b0, CmdState}, 8'h00);
        wr(8'hFF);
        chk("t3_bank", RWBank, 8'hF0);

        rst();
        key(6); wr(8'hFF); wr(8'h5A);
        chk("t4_bank0", RWBank, 8'h00);
        wr(8'h12);
        chk("t4_bank12", RWBank, 8'h12);

        rst();
        key(4);
        for (int k = 0; k < 8; k++) cyc();
        chk("t5_cs", {5'b0, CmdState}, 8'h00);
        wr(8'hAD);
        chk("t5_no_cs6", {5'b0, CmdState}, 8'h00);

        rst();
        key(2);
        for (int k = 0; k < 7; k++) cyc();
        step(0, 1, 8'h55, 1, 0, 8'h00);
        chk("t5_write_wins", {5'b0, CmdState}, 8'h03);

        rst();
        step(0, 0, 8'h00, 0, 1, 8'h80);
        chk("t6_mask80", RWMask, 8'h00);
        step(0, 0, 8'h00, 0, 1, 8'h3F);
        chk("t6_mask3f", RWMask, 8'hC0);
        key(6); wr(8'hE0);
        step(0, 1, 8'h00, 0, 1, 8'h3F);
        chk("t6_init_wins", RWMask, 8'hC0);

        rst();
        key(6); wr(8'hEA); wr(8'hC0);
        chk("bb_din", {7'b0, BbDRDIn}, 8'h01);
        chk("bb_clk", {7'b0, BbDRCLK}, 8'h01);
        idle();
        chk("bb_clk_off", {7'b0, BbDRCLK}, 8'h00);
        chk("bb_din_hold", {7'b0, BbDRDIn}, 8'h01);

        key(5);
        chk("t6_cs5", {5'b0, CmdState}, 8'h05);
        rst();
        chk("t6_rst_cs", {5'b0, CmdState}, 8'h00);
        chk("t6_rst_bank", RWBank, 8'h00);
        chk("t6_rst_pulse", {6'b0, CmdPrgm, CmdErase}, 8'h00);

        for (int i = 0; i < 4000; i++) begin
            bit         r_rst;
            bit         r_wr;
            bit         r_cyc;
            bit         r_iv;
            logic [7:0] r_d;
            int         pct;
            pct   = ((i % 400) < 200) ? 60 : 12;
            r_rst = ($urandom_range(0, 199) == 0);
            r_wr  = ($urandom_range(0, 99) < pct);
            r_cyc = ($urandom_range(0, 2) != 0);
            r_iv  = ($urandom_range(0, 49) == 0);
            r_d   = 8'($urandom);
            if (m_cs < 6 && $urandom_range(0, 9) < 8) r_d = KEY[m_cs];
            else if (m_cs == 6) r_d = CMDS[$urandom_range(0, 5)];
            step(r_rst, r_wr, r_d, r_cyc, r_iv, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
